// File: rtl/lp4200_adc_scanner.sv
// lp4200_adc_scanner
// SPI mode-0 master that round-robins channels 0..5 of an MCP3208-class
// 12-bit SAR ADC. Each 24-bit frame carries start/single-ended/channel on
// MOSI bits 5..9 and returns the conversion on MISO bits 12..23 (MSB first).
// Each conversion is published atomically into its own result register
// together with sample_valid/sample_ch, plus scan_done on channel 5.
//
// Handshake: there is no back-pressure. sample_valid is a single-cycle
// strobe meaning "the result register for sample_ch was written at the
// clock edge that began this cycle"; consumers must capture it in that cycle.
module lp4200_adc_scanner #(
    parameter int CLK_DIV = 4,   // clk cycles per SCLK half-period (>= 2)
    parameter int CS_IDLE = 8    // clk cycles CS stays high between frames (>= 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_mosi,
    output logic [11:0] micro_usb_voltage,
    output logic [11:0] jack_voltage,
    output logic [11:0] battery_voltage,
    output logic [11:0] battery_current,
    output logic [11:0] battery_temp,
    output logic [11:0] system_current,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic        scan_done,
    output logic        all_valid,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // One counter serves every state; it must reach a full SCLK bit or the
    // CS idle gap, whichever is longer.
    localparam int CNT_MAX = (2 * CLK_DIV > CS_IDLE) ? 2 * CLK_DIV : CS_IDLE;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HIGH_START = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_IDLE - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [4:0]       bit_idx, bit_d;
    logic [2:0]       ch, ch_d;
    logic [11:0]      shreg, shift_d;
    logic             upd;
    logic             mosi_d, sclk_d, cs_n_d;

    assign dbg_state = state;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, counters, receive shift and the next values of the pins.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        bit_d   = bit_idx;
        ch_d    = ch;
        shift_d = shreg;
        upd     = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = S_SETUP;
                    ch_d    = 3'd0;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 5'd0;
                end
            end
            S_SHIFT: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    // Only the last 12 bits carry the conversion result.
                    if (bit_idx >= 5'd12) begin
                        shift_d = {shreg[10:0], adc_miso};
                    end
                    if (bit_idx == 5'd23) begin
                        state_d = S_HOLD;
                        upd     = 1'b1;
                    end else begin
                        bit_d = bit_idx + 5'd1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = S_SETUP;
                        ch_d    = (ch == 3'd5) ? 3'd0 : ch + 3'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // MOSI is a pure function of the bit index, so it only moves at the
        // start of a low phase and is stable across every high phase.
        mosi_d = 1'b0;
        if (state_d == S_SHIFT) begin
            case (bit_d)
                5'd5, 5'd6: mosi_d = 1'b1;
                5'd7:       mosi_d = ch_d[2];
                5'd8:       mosi_d = ch_d[1];
                5'd9:       mosi_d = ch_d[0];
                default:    mosi_d = 1'b0;
            endcase
        end
        sclk_d = (state_d == S_SHIFT) && (cnt_d >= HIGH_START);
        cs_n_d = !((state_d == S_SETUP) || (state_d == S_SHIFT));
    end

    // Datapath registers and glitch-free registered SPI pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= 5'd0;
            ch       <= 3'd0;
            shreg    <= 12'd0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            adc_mosi <= 1'b0;
            busy     <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            bit_idx  <= bit_d;
            ch       <= ch_d;
            shreg    <= shift_d;
            adc_cs_n <= cs_n_d;
            adc_sclk <= sclk_d;
            adc_mosi <= mosi_d;
            busy     <= (state_d != S_IDLE);
        end
    end

    // Result registers and strobes; written only on the frame-complete edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            micro_usb_voltage <= 12'd0;
            jack_voltage      <= 12'd0;
            battery_voltage   <= 12'd0;
            battery_current   <= 12'd0;
            battery_temp      <= 12'd0;
            system_current    <= 12'd0;
            sample_valid      <= 1'b0;
            sample_ch         <= 3'd0;
            scan_done         <= 1'b0;
            all_valid         <= 1'b0;
        end else begin
            sample_valid <= upd;
            scan_done    <= upd && (ch == 3'd5);
            if (upd) begin
                sample_ch <= ch;
                if (ch == 3'd5) begin
                    all_valid <= 1'b1;
                end
                case (ch)
                    3'd0:    micro_usb_voltage <= shift_d;
                    3'd1:    jack_voltage      <= shift_d;
                    3'd2:    battery_voltage   <= shift_d;
                    3'd3:    battery_current   <= shift_d;
                    3'd4:    battery_temp      <= shift_d;
                    3'd5:    system_current    <= shift_d;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lp4200_adc_scanner.sv
// Bench for lp4200_adc_scanner: an MCP3208-style ADC model answers each
// frame, directed sequences push the expected {channel, value} per frame,
// and a monitor pops and compares on every sample_valid.
module tb_lp4200_adc_scanner;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic adc_miso = 1'b0;
    always #5 clk = ~clk;

    logic        adc_cs_n, adc_sclk, adc_mosi;
    logic [11:0] micro_usb_voltage, jack_voltage, battery_voltage;
    logic [11:0] battery_current, battery_temp, system_current;
    logic        sample_valid, scan_done, all_valid, busy;
    logic [2:0]  sample_ch;
    logic [1:0]  dbg_state;

    lp4200_adc_scanner #(.CLK_DIV(4), .CS_IDLE(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .adc_miso(adc_miso),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi),
        .micro_usb_voltage(micro_usb_voltage), .jack_voltage(jack_voltage),
        .battery_voltage(battery_voltage), .battery_current(battery_current),
        .battery_temp(battery_temp), .system_current(system_current),
        .sample_valid(sample_valid), .sample_ch(sample_ch),
        .scan_done(scan_done), .all_valid(all_valid), .busy(busy),
        .dbg_state(dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ADC model ----------------
    logic [11:0] adc_val[0:7];
    logic [23:0] mdl_word = '0;
    int          mdl_idx = 0;
    logic [2:0]  mdl_ch = 3'd7;
    int          sclk_rises = 0;

    always @(negedge adc_cs_n) begin
        mdl_idx  = 0;
        mdl_word = '0;
        mdl_ch   = 3'd7;
    end

    always @(posedge adc_sclk) begin
        sclk_rises++;
        if (!adc_cs_n && mdl_idx < 24) begin
            mdl_word[23-mdl_idx] = adc_mosi;
            if (mdl_idx == 9) mdl_ch = mdl_word[16:14];
            // Junk on the bits the master must ignore, data on bits 12..23.
            if (mdl_idx >= 12) adc_miso = adc_val[mdl_ch][23-mdl_idx];
            else               adc_miso = 1'($urandom_range(0, 1));
            mdl_idx++;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [14:0] exp_q[$];
    logic [11:0] shadow[0:7];
    logic        av_exp = 1'b0;
    int          mon_count = 0;
    int          last_sv_cyc = 0;
    int          sd_count = 0;

    task automatic push_exp(input logic [2:0] c, input logic [11:0] v);
        exp_q.push_back({c, v});
    endtask

    initial for (int i = 0; i < 8; i++) shadow[i] = 12'd0;

    always @(negedge clk) begin
        logic [14:0] e;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) shadow[i] = 12'd0;
            av_exp = 1'b0;
        end else if (sample_valid) begin
            mon_count++;
            last_sv_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got ch %0d expected none", sample_ch);
            end else begin
                e = exp_q.pop_front();
                shadow[e[14:12]] = e[11:0];
                check("sample_ch", sample_ch, e[14:12]);
                check("mosi_frame", mdl_word, {5'b0, 2'b11, e[14:12], 14'b0});
                check("scan_done_on_sample", scan_done, e[14:12] == 3'd5);
                if (e[14:12] == 3'd5) av_exp = 1'b1;
            end
        end
        if (scan_done) sd_count++;
        if (!sample_valid) check("scan_done_idle", scan_done, 1'b0);
        check("all_valid", all_valid, av_exp);
        if (adc_cs_n) check("sclk_low_when_cs_high", adc_sclk, 1'b0);
        check("results",
              {micro_usb_voltage, jack_voltage, battery_voltage,
               battery_current, battery_temp, system_current},
              {shadow[0], shadow[1], shadow[2], shadow[3], shadow[4], shadow[5]});
    end

    // ---------------- driver tasks ----------------
    task automatic wait_samples(input int target, input int budget, input string name);
        int n = 0;
        while (mon_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, mon_count >= target, 1'b1);
    endtask

    task automatic wait_bit(input logic [2:0] c, input int idx, input int budget, input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(mdl_ch == c && mdl_idx == idx && !adc_cs_n) && n < budget);
        check({name, "_timeout"}, (mdl_ch == c && mdl_idx == idx), 1'b1);
    endtask

    task automatic busy_fall(input string name);
        int rel = -1;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                rel = cyc - last_sv_cyc;
                break;
            end
        end
        check(name, rel, 8);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, cs_fall, sclk_first, base, cs_low, busy_hi, r0;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;

        // Reset values
        repeat (5) @(posedge clk);
        #1;
        check("rst_cs_n", adc_cs_n, 1'b1);
        check("rst_sclk", adc_sclk, 1'b0);
        check("rst_mosi", adc_mosi, 1'b0);
        check("rst_sample_valid", sample_valid, 1'b0);
        check("rst_sample_ch", sample_ch, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;

        // Idle with enable low: no SPI activity for 1000 cycles
        r0 = sclk_rises; cs_low = 0; busy_hi = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (!adc_cs_n) cs_low++;
            if (busy) busy_hi++;
        end
        check("idle_sclk_edges", sclk_rises - r0, 0);
        check("idle_busy_cycles", busy_hi, 0);
        check("idle_cs_low_cycles", cs_low, 0);

        // Single ch0 frame with timing
        adc_val[0] = 12'hABC;
        push_exp(3'd0, 12'hABC);
        @(posedge clk);
        #1;
        enable = 1'b1;
        t0 = cyc; cs_fall = -1; sclk_first = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (!adc_cs_n && cs_fall < 0) cs_fall = k;
            if (adc_sclk && sclk_first < 0) sclk_first = k;
        end
        enable = 1'b0;   // dropped during HOLD, seen only at its end
        check("cs_fall_cycle", cs_fall, 1);
        check("first_sclk_cycle", sclk_first, 9);
        check("first_sample_cycle", last_sv_cyc - t0, 197);
        check("micro_usb_voltage", micro_usb_voltage, 12'hABC);
        busy_fall("busy_fall_after_hold_ch0");

        // Full scan 0x100+ch
        for (int c = 0; c < 6; c++) begin
            adc_val[c] = 12'h100 + 12'(c);
            push_exp(3'(c), 12'h100 + 12'(c));
        end
        base = mon_count;
        @(posedge clk);
        #1;
        enable = 1'b1;
        t0 = cyc;
        wait_samples(base + 6, 3000, "scan1");
        check("scan1_last_sample_cycle", last_sv_cyc - t0, 1217);
        check("scan1_scan_done_count", sd_count, 1);
        check("scan1_all_valid", all_valid, 1'b1);
        check("scan1_outputs",
              {micro_usb_voltage, jack_voltage, battery_voltage,
               battery_current, battery_temp, system_current},
              {12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105});

        // Second scan: wraps to ch0, ch2 at full scale
        adc_val[2] = 12'hFFF;
        for (int c = 0; c < 6; c++) push_exp(3'(c), adc_val[c]);
        wait_samples(base + 12, 3000, "scan2");
        check("battery_voltage_fff", battery_voltage, 12'hFFF);
        check("scan2_scan_done_count", sd_count, 2);

        // Third scan: ch2 at zero; enable drops at bit 15 of ch3
        adc_val[2] = 12'h000;
        for (int c = 0; c < 4; c++) push_exp(3'(c), adc_val[c]);
        wait_bit(3'd3, 16, 3000, "ch3_bit15");
        enable = 1'b0;
        wait_samples(base + 16, 1000, "scan3");
        check("battery_voltage_000", battery_voltage, 12'h000);
        check("battery_current_ch3", battery_current, 12'h103);
        busy_fall("busy_fall_after_disable");
        r0 = sclk_rises; cs_low = 0; busy_hi = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (!adc_cs_n) cs_low++;
            if (busy) busy_hi++;
        end
        check("disabled_cs_low_cycles", cs_low, 0);
        check("disabled_sclk_edges", sclk_rises - r0, 0);
        check("disabled_busy_cycles", busy_hi, 0);

        // Re-enable restarts at ch0; reset lands at bit 18 of ch4
        for (int c = 0; c < 4; c++) push_exp(3'(c), adc_val[c]);
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_samples(base + 20, 1500, "rescan");
        wait_bit(3'd4, 19, 600, "ch4_bit18");
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_rst_cs_n", adc_cs_n, 1'b1);
        check("midframe_rst_sclk", adc_sclk, 1'b0);
        check("midframe_rst_battery_temp", battery_temp, 12'h000);
        check("midframe_rst_all_valid", all_valid, 1'b0);
        check("midframe_rst_busy", busy, 1'b0);
        check("midframe_rst_micro", micro_usb_voltage, 12'h000);
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("final_busy", busy, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
